// File: rtl/edp_slice_gen.sv
// One WIDTH-bit slice of the EDP data path: AR/ARX/BR/BRX/MQ, the AD adder slice,
// a parity-protected fast-memory AC block with registered read, and an EBUS readback mux.
module edp_slice_gen #(
   parameter int unsigned WIDTH       = 6,
   parameter int unsigned FM_ADR_BITS = 4,
   parameter int unsigned FM_BLK_BITS = 3
) (
   input  logic                   clk_edp_h,
   input  logic                   reset_l,
   input  logic                   ar_clr_h,
   input  logic                   ar_load_h,
   input  logic [2:0]             ar_sel_h,
   input  logic                   arx_load_h,
   input  logic [1:0]             arx_sel_h,
   input  logic                   br_load_h,
   input  logic                   brx_load_h,
   input  logic [1:0]             mq_sel_h,
   input  logic [WIDTH-1:0]       armm_h,
   input  logic [WIDTH-1:0]       cache_data_h,
   input  logic [WIDTH-1:0]       sh_h,
   input  logic [WIDTH-1:0]       vma_held_or_pc_h,
   input  logic                   shin_left_h,
   input  logic                   shin_right_h,
   output logic                   shout_msb_h,
   output logic                   shout_lsb_h,
   input  logic [1:0]             ada_sel_h,
   input  logic                   ada_dis_h,
   input  logic [1:0]             adb_sel_h,
   input  logic                   ad_boole_h,
   input  logic [2:0]             ad_func_h,
   input  logic                   ad_cry_in_h,
   output logic [WIDTH-1:0]       ad_h,
   output logic                   ad_cry_out_h,
   output logic                   ad_cg_h,
   output logic                   ad_cp_h,
   output logic                   ad_overflow_h,
   output logic                   ad_eq0_l,
   output logic [WIDTH-1:0]       ar_h,
   output logic [WIDTH-1:0]       arx_h,
   output logic [WIDTH-1:0]       br_h,
   output logic [WIDTH-1:0]       brx_h,
   output logic [WIDTH-1:0]       mq_h,
   input  logic [FM_ADR_BITS-1:0] fm_adr_h,
   input  logic [FM_BLK_BITS-1:0] fm_block_h,
   input  logic                   fm_write_l,
   input  logic                   fm_check_en_h,
   input  logic                   fm_err_clr_h,
   output logic [WIDTH-1:0]       fm_data_h,
   output logic                   fm_parity_h,
   output logic                   fm_parity_err_h,
   input  logic                   ad_to_ebus_h,
   input  logic                   diag_read_h,
   input  logic [2:0]             diag_sel_h,
   output logic [WIDTH-1:0]       ebus_d_h,
   output logic                   ebus_en_h
);

   localparam int unsigned FM_AW    = FM_ADR_BITS + FM_BLK_BITS;
   localparam int unsigned FM_DEPTH = 1 << FM_AW;

   logic [WIDTH-1:0] fm_mem [FM_DEPTH];
   logic             fm_par [FM_DEPTH];
   logic [FM_AW-1:0] fm_adr_q;

   logic [WIDTH-1:0] a_op, b_op, op1, op2, ar_src, arx_src;
   logic [WIDTH:0]   sum;
   logic             fm_err_set;

   always_comb begin
      a_op = '0;
      if (!ada_dis_h) begin
         case (ada_sel_h)
            2'd0:    a_op = ar_h;
            2'd1:    a_op = arx_h;
            2'd2:    a_op = mq_h;
            default: a_op = vma_held_or_pc_h;
         endcase
      end
      case (adb_sel_h)
         2'd0:    b_op = fm_data_h;
         2'd1:    b_op = br_h;
         2'd2:    b_op = brx_h;
         default: b_op = ar_h;
      endcase
   end

   // Generate is recovered from the carry-out: with XOR propagate, G and P are exclusive,
   // so cout = G | (P & cin) gives G = cout & ~(P & cin) without a second adder.
   always_comb begin
      op1           = a_op;
      op2           = b_op;
      sum           = '0;
      ad_h          = '0;
      ad_cry_out_h  = 1'b0;
      ad_cg_h       = 1'b0;
      ad_cp_h       = 1'b0;
      ad_overflow_h = 1'b0;
      if (ad_boole_h) begin
         case (ad_func_h)
            3'd0:    ad_h = a_op & b_op;
            3'd1:    ad_h = a_op | b_op;
            3'd2:    ad_h = a_op ^ b_op;
            3'd3:    ad_h = ~a_op;
            3'd4:    ad_h = a_op;
            3'd5:    ad_h = b_op;
            3'd6:    ad_h = '0;
            default: ad_h = '1;
         endcase
      end else begin
         case (ad_func_h)
            3'd1:    op2 = ~b_op;
            3'd2:    op2 = a_op;
            3'd3:    op2 = '0;
            default: op2 = b_op;
         endcase
         sum           = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, ad_cry_in_h};
         ad_h          = sum[WIDTH-1:0];
         ad_cry_out_h  = sum[WIDTH];
         ad_cp_h       = &(op1 ^ op2);
         ad_cg_h       = sum[WIDTH] & ~(ad_cp_h & ad_cry_in_h);
         ad_overflow_h = (op1[WIDTH-1] ^ op2[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
      end
   end

   assign ad_eq0_l    = |ad_h;
   assign shout_msb_h = ad_h[WIDTH-1];
   assign shout_lsb_h = ad_h[0];

   always_comb begin
      case (ar_sel_h)
         3'd0:    ar_src = armm_h;
         3'd1:    ar_src = cache_data_h;
         3'd2:    ar_src = ad_h;
         3'd3:    ar_src = sh_h;
         3'd4:    ar_src = {ad_h[WIDTH-2:0], shin_left_h};
         3'd5:    ar_src = {shin_right_h, ad_h[WIDTH-1:1]};
         3'd6:    ar_src = vma_held_or_pc_h;
         default: ar_src = '0;
      endcase
      case (arx_sel_h)
         2'd0:    arx_src = mq_h;
         2'd1:    arx_src = cache_data_h;
         2'd2:    arx_src = ad_h;
         default: arx_src = sh_h;
      endcase
   end

   assign fm_data_h   = fm_mem[fm_adr_q];
   assign fm_parity_h = fm_par[fm_adr_q];
   assign fm_err_set  = fm_check_en_h & ~(^{fm_data_h, fm_parity_h});

   always_ff @(posedge clk_edp_h) begin
      if (!reset_l) begin
         ar_h            <= '0;
         arx_h           <= '0;
         br_h            <= '0;
         brx_h           <= '0;
         mq_h            <= '0;
         fm_adr_q        <= '0;
         fm_parity_err_h <= 1'b0;
      end else begin
         if (ar_clr_h)       ar_h <= '0;
         else if (ar_load_h) ar_h <= ar_src;
         if (arx_load_h) arx_h <= arx_src;
         if (br_load_h)  br_h  <= ar_h;
         if (brx_load_h) brx_h <= arx_h;
         case (mq_sel_h)
            2'd1:    mq_h <= {mq_h[WIDTH-2:0], shin_left_h};
            2'd2:    mq_h <= {shin_right_h, mq_h[WIDTH-1:1]};
            2'd3:    mq_h <= ad_h;
            default: ;
         endcase
         fm_adr_q        <= {fm_block_h, fm_adr_h};
         fm_parity_err_h <= fm_err_set | (fm_parity_err_h & ~fm_err_clr_h);
      end
   end

   // Array has no reset; a write is simply suppressed while reset is asserted.
   always_ff @(posedge clk_edp_h) begin
      if (reset_l && !fm_write_l) begin
         fm_mem[{fm_block_h, fm_adr_h}] <= ar_h;
         fm_par[{fm_block_h, fm_adr_h}] <= ~^ar_h;
      end
   end

   always_comb begin
      ebus_d_h = '0;
      if (ad_to_ebus_h) begin
         ebus_d_h = ad_h;
      end else if (diag_read_h) begin
         case (diag_sel_h)
            3'd0:    ebus_d_h = ar_h;
            3'd1:    ebus_d_h = arx_h;
            3'd2:    ebus_d_h = br_h;
            3'd3:    ebus_d_h = brx_h;
            3'd4:    ebus_d_h = mq_h;
            3'd5:    ebus_d_h = fm_data_h;
            3'd6:    ebus_d_h = ad_h;
            default: ebus_d_h = '0;
         endcase
      end
   end

   assign ebus_en_h = ad_to_ebus_h | diag_read_h;

endmodule

// File: doc/edp_slice_gen.md
Name: edp_slice_gen

Overview:
- Parametrised successor to the fixed 6-bit EDP data-path slice.
- One instance holds WIDTH bits of the AR, ARX, BR, BRX and MQ registers, plus the matching slice of the AD adder and of the fast-memory (FM) AC blocks.
- Adds behaviour the fixed slice lacks: registered FM read with stored parity, a sticky FM parity-error flag, and a diagnostic EBUS readback mux.
- Slices cascade through the carry and shift-in/out ports to form the full data path.

Parameters:
WIDTH, 6, bits per slice
FM_ADR_BITS, 4, AC address bits within a block
FM_BLK_BITS, 3, AC block-select bits (FM depth = 2^(FM_ADR_BITS+FM_BLK_BITS))

Ports:
clk_edp_h  in  1  slice clock, rising edge
reset_l  in  1  synchronous reset, active low
ar_clr_h  in  1  clear AR
ar_load_h  in  1  load AR from ar_sel_h source
ar_sel_h  in  3  0 armm, 1 cache_data, 2 AD, 3 sh, 4 AD<<1, 5 AD>>1, 6 vma_held_or_pc, 7 zero
arx_load_h  in  1  load ARX
arx_sel_h  in  2  0 MQ, 1 cache_data, 2 AD, 3 sh
br_load_h  in  1  BR <= AR
brx_load_h  in  1  BRX <= ARX
mq_sel_h  in  2  0 hold, 1 shift left, 2 shift right, 3 load AD
armm_h, cache_data_h, sh_h, vma_held_or_pc_h  in  WIDTH  data sources
shin_left_h  in  1  bit entering LSB on left shifts (from the lower-order slice)
shin_right_h  in  1  bit entering MSB on right shifts (from the higher-order slice)
shout_msb_h, shout_lsb_h  out  1  AD MSB / AD LSB, for neighbouring slices
ada_sel_h  in  2  A operand: 0 AR, 1 ARX, 2 MQ, 3 vma_held_or_pc
ada_dis_h  in  1  force A = 0
adb_sel_h  in  2  B operand: 0 FM data, 1 BR, 2 BRX, 3 AR
ad_boole_h  in  1  1 logical, 0 arithmetic
ad_func_h  in  3  function code (see Behaviour)
ad_cry_in_h  in  1  carry into LSB
ad_h  out  WIDTH  AD result
ad_cry_out_h, ad_cg_h, ad_cp_h  out  1  carry out, group generate, group propagate
ad_overflow_h  out  1  carry into MSB XOR carry out
ad_eq0_l  out  1  low when AD == 0
ar_h, arx_h, br_h, brx_h, mq_h  out  WIDTH  register values
fm_adr_h  in  FM_ADR_BITS  AC address
fm_block_h  in  FM_BLK_BITS  AC block
fm_write_l  in  1  write AR into FM, active low
fm_check_en_h  in  1  enable parity checking
fm_err_clr_h  in  1  clear parity-error flag
fm_data_h  out  WIDTH  FM read data
fm_parity_h  out  1  stored parity bit
fm_parity_err_h  out  1  sticky parity error
ad_to_ebus_h  in  1  drive AD onto EBUS
diag_read_h  in  1  diagnostic read
diag_sel_h  in  3  0 AR, 1 ARX, 2 BR, 3 BRX, 4 MQ, 5 FM data, 6 AD, 7 zero
ebus_d_h  out  WIDTH  EBUS data
ebus_en_h  out  1  slice is driving EBUS

Behaviour:
- Reset (reset_l low at a clock edge):
  - AR, ARX, BR, BRX, MQ, the registered FM address and fm_parity_err_h all go to 0.
  - FM array contents are not touched.
  - Reset overrides every other control in that cycle.
- Registers (all updated on the rising clk_edp_h edge; sources sample pre-edge values):
  - AR: ar_clr_h beats ar_load_h.
  - ARX: loads on arx_load_h.
  - BR/BRX: take the old AR/ARX even when AR/ARX load in the same cycle.
  - MQ shift left: {mq[W-2:0], shin_left_h}.
  - MQ shift right: {shin_right_h, mq[W-1:1]}.
- AR shift sources:
  - Source 4: {AD[W-2:0], shin_left_h}.
  - Source 5: {shin_right_h, AD[W-1:1]}.
- AD is combinational. A = 0 when ada_dis_h is set.
- Arithmetic (ad_boole_h = 0):
  - Function codes: 0 A+B+cin, 1 A+~B+cin, 2 A+A+cin, 3 A+cin, 4-7 same as 0.
  - Sum is WIDTH+1 bits; the top bit is ad_cry_out_h.
  - ad_cg_h / ad_cp_h are the group generate/propagate of the effective operands, with cin excluded.
- Boolean (ad_boole_h = 1):
  - Function codes: 0 A&B, 1 A|B, 2 A^B, 3 ~A, 4 A, 5 B, 6 all 0, 7 all 1.
  - Carry out, cg, cp and overflow are all 0.
- FM write: on a clock edge with fm_write_l = 0, word {block, adr} <= AR, and its parity bit <= odd parity of AR (XNOR-reduce).
- FM read:
  - {block, adr} is registered every clock.
  - fm_data_h / fm_parity_h come from the registered address, giving one-cycle latency.
  - A write followed by a read of the same address shows the new data in the cycle after the write.
- Parity error flag:
  - Sets when fm_check_en_h = 1 and odd parity of {fm_data_h, fm_parity_h} fails.
  - Stays set until fm_err_clr_h or reset.
  - If set and clear occur in the same cycle, set wins.
- EBUS:
  - ad_to_ebus_h has priority: ebus_d_h = AD.
  - Otherwise, with diag_read_h: the diag_sel_h source.
  - Otherwise: 0.
  - ebus_en_h = ad_to_ebus_h | diag_read_h.
- Reading unwritten FM words is undefined. Benches write every word before reading it.

Test Plan:
- Reset: with registers loaded, drop reset_l for one edge -> AR, ARX, BR, BRX, MQ = 0 and fm_parity_err_h = 0; previously written FM data is still readable.
- Adder: A = AR = 6'o77, B = BR = 6'o01, func 0, cin 0 -> AD = 0, carry out 1, ad_eq0_l = 0. Same operands with func 1, cin 1 -> AD = 6'o76, carry out 1.
- Shift: MQ = 6'b101100, shift left with shin_left_h = 1 -> 6'b011001; then shift right with shin_right_h = 0 -> 6'b001100.
- FM: write AR = 6'o52 to block 3 adr 5; read it back -> fm_data_h = 6'o52 one cycle after the address, fm_parity_h = 0 (odd parity). Corrupt the stored parity via a hierarchical force with fm_check_en_h = 1 -> fm_parity_err_h = 1; it clears only on fm_err_clr_h.
- Simultaneous events: ar_load and br_load in the same cycle with AR = 6'o11 and new AR source = 6'o22 -> BR = 6'o11, AR = 6'o22. ar_clr_h plus ar_load_h -> AR = 0.
- EBUS: diag_read_h with diag_sel 4 and MQ = 6'o07 -> ebus_d_h = 6'o07, ebus_en_h = 1. Asserting ad_to_ebus_h as well -> ebus_d_h = AD.
